// File: rtl/world_scheduler.sv
// world_scheduler
//   Walks the world cube memory one entry at a time and hands every valid
//   cube to a free cube_drawer lane, choosing lanes round-robin. One entry
//   is fetched per FETCH/WAIT/DISPATCH round trip; there is no prefetch.
//   An abort stops further dispatch, lets the busy lanes finish, and then
//   ends the scan with done and aborted both high.
//
// Ports
//   clk_in           system clock
//   rst_n_in         synchronous reset, active low
//   start            begin a scan (only accepted when idle)
//   abort            stop dispatching, drain the lanes, then finish
//   world_read       world entry {valid, x, y, z}; z sits in the LSBs
//   world_read_addr  world memory read address
//   lane_start       one-cycle start pulse per lane
//   lane_x/y/z_corner  per-lane corners, packed, lane i at [i*COORD_WIDTH +: COORD_WIDTH]
//   lane_done        one-cycle completion pulse from each lane
//   busy             high from an accepted start until the done pulse
//   done             one-cycle pulse when the scan is over and all lanes are idle
//   aborted          set when the scan ended by abort; cleared by the next start
//   cubes_drawn      valid cubes dispatched during this scan
//   cubes_skipped    invalid entries skipped during this scan
//
// COORD_WIDTH is expected to be even; world fields are COORD_WIDTH/2 bits.
module world_scheduler #(
    parameter int COORD_WIDTH  = 32,
    parameter int WORLD_SIZE   = 100,
    parameter int WORLD_BITS   = 7,
    parameter int READ_LATENCY = 2,
    parameter int NUM_LANES    = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             start,
    input  logic                             abort,
    input  logic [3*(COORD_WIDTH/2):0]       world_read,
    output logic [WORLD_BITS-1:0]            world_read_addr,
    output logic [NUM_LANES-1:0]             lane_start,
    output logic [NUM_LANES*COORD_WIDTH-1:0] lane_x_corner,
    output logic [NUM_LANES*COORD_WIDTH-1:0] lane_y_corner,
    output logic [NUM_LANES*COORD_WIDTH-1:0] lane_z_corner,
    input  logic [NUM_LANES-1:0]             lane_done,
    output logic                             busy,
    output logic                             done,
    output logic                             aborted,
    output logic [WORLD_BITS:0]              cubes_drawn,
    output logic [WORLD_BITS:0]              cubes_skipped
);

    localparam int HALF    = COORD_WIDTH / 2;
    localparam int ENTRY_W = 3 * HALF + 1;
    localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_WAIT     = 3'd2;
    localparam logic [2:0] ST_DISPATCH = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [WORLD_BITS-1:0] addr_q, addr_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [ENTRY_W-1:0]    entry_q, entry_d;
    logic [LANE_W-1:0]     rr_q, rr_d;
    logic [NUM_LANES-1:0]  lane_active_q, lane_active_d;
    logic [NUM_LANES-1:0]  lane_start_q, lane_start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic [WORLD_BITS:0]   drawn_q, drawn_d;
    logic [WORLD_BITS:0]   skipped_q, skipped_d;

    logic                  pick_found;
    logic [LANE_W-1:0]     pick_lane;
    logic                  fire;
    logic                  advance;

    logic                  entry_valid;
    logic [HALF-1:0]       entry_x, entry_y, entry_z;

    assign entry_valid = entry_q[ENTRY_W-1];
    assign entry_x     = entry_q[3*HALF-1:2*HALF];
    assign entry_y     = entry_q[2*HALF-1:HALF];
    assign entry_z     = entry_q[HALF-1:0];

    // First free lane at or after the round-robin pointer. Uses the
    // registered busy flags, so a lane finishing this very cycle is still
    // treated as busy and can only be picked one cycle later.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_lane  = '0;
        idx        = 0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_LANES) begin
                idx = idx - NUM_LANES;
            end
            if (!lane_active_q[LANE_W'(idx)]) begin
                pick_found = 1'b1;
                pick_lane  = LANE_W'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        lat_d         = lat_q;
        entry_d       = entry_q;
        rr_d          = rr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        aborted_d     = aborted_q;
        drawn_d       = drawn_q;
        skipped_d     = skipped_q;
        lane_start_d  = '0;
        lane_active_d = lane_active_q & ~lane_done;
        fire          = 1'b0;
        advance       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = '0;
                    drawn_d   = '0;
                    skipped_d = '0;
                    aborted_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                lat_d = '0;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
                    entry_d = world_read;
                    state_d = ST_DISPATCH;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_DISPATCH: begin
                // Abort wins over a dispatch that would happen this cycle.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (!entry_valid) begin
                    skipped_d = skipped_q + 1'b1;
                    advance   = 1'b1;
                end else if (pick_found) begin
                    fire      = 1'b1;
                    drawn_d   = drawn_q + 1'b1;
                    advance   = 1'b1;
                    lane_start_d[pick_lane]  = 1'b1;
                    lane_active_d[pick_lane] = 1'b1;
                    if (pick_lane == LANE_W'(NUM_LANES - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = pick_lane + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (lane_active_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (addr_q == WORLD_BITS'(WORLD_SIZE - 1)) begin
                state_d = ST_DRAIN;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            lat_q         <= '0;
            entry_q       <= '0;
            rr_q          <= '0;
            lane_active_q <= '0;
            lane_start_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            drawn_q       <= '0;
            skipped_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            lat_q         <= lat_d;
            entry_q       <= entry_d;
            rr_q          <= rr_d;
            lane_active_q <= lane_active_d;
            lane_start_q  <= lane_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            drawn_q       <= drawn_d;
            skipped_q     <= skipped_d;
        end
    end

    // Per-lane corner registers: the world field lands in the upper half,
    // which keeps its sign, with zero fraction bits below.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [COORD_WIDTH-1:0] x_q, y_q, z_q;

            always_ff @(posedge clk_in) begin
                if (!rst_n_in) begin
                    x_q <= '0;
                    y_q <= '0;
                    z_q <= '0;
                end else if (fire && (pick_lane == LANE_W'(gi))) begin
                    x_q <= COORD_WIDTH'({entry_x, {HALF{1'b0}}});
                    y_q <= COORD_WIDTH'({entry_y, {HALF{1'b0}}});
                    z_q <= COORD_WIDTH'({entry_z, {HALF{1'b0}}});
                end
            end

            assign lane_x_corner[gi*COORD_WIDTH +: COORD_WIDTH] = x_q;
            assign lane_y_corner[gi*COORD_WIDTH +: COORD_WIDTH] = y_q;
            assign lane_z_corner[gi*COORD_WIDTH +: COORD_WIDTH] = z_q;
        end
    endgenerate

    assign world_read_addr = addr_q;
    assign lane_start      = lane_start_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign cubes_drawn     = drawn_q;
    assign cubes_skipped   = skipped_q;

endmodule

// File: tb/tb_world_scheduler.sv
// Bench for world_scheduler: a behavioural world memory with fixed read
// latency, per-lane drawer models with programmable draw time, and a
// lane/corner scoreboard built from the world contents.
module tb_world_scheduler;

    localparam int CW  = 32;
    localparam int WS  = 100;
    localparam int WB  = 7;
    localparam int LAT = 2;
    localparam int NL  = 2;

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] z;
    } corner_t;

    logic                clk_in = 1'b0;
    logic                rst_n_in = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [48:0]         world_read;
    logic [WB-1:0]       world_read_addr;
    logic [NL-1:0]       lane_start;
    logic [NL*CW-1:0]    lane_x_corner, lane_y_corner, lane_z_corner;
    logic [NL-1:0]       lane_done = '0;
    logic                busy, done, aborted;
    logic [WB:0]         cubes_drawn, cubes_skipped;

    world_scheduler #(
        .COORD_WIDTH(CW), .WORLD_SIZE(WS), .WORLD_BITS(WB),
        .READ_LATENCY(LAT), .NUM_LANES(NL)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start(start), .abort(abort),
        .world_read(world_read), .world_read_addr(world_read_addr),
        .lane_start(lane_start), .lane_x_corner(lane_x_corner),
        .lane_y_corner(lane_y_corner), .lane_z_corner(lane_z_corner),
        .lane_done(lane_done), .busy(busy), .done(done), .aborted(aborted),
        .cubes_drawn(cubes_drawn), .cubes_skipped(cubes_skipped)
    );

    always #5 clk_in = ~clk_in;

    // World memory with LAT register stages between address and data.
    logic [48:0] mem [WS];
    logic [48:0] pipe [LAT];
    always @(posedge clk_in) begin
        pipe[0] <= (int'(world_read_addr) < WS) ? mem[world_read_addr] : 49'd0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign world_read = pipe[LAT-1];

    // Drawer lanes: lane_done pulses draw-time cycles after lane_start.
    int dcnt [NL];
    int dt_fix = 10;
    bit dt_rand = 1'b0;
    always begin
        @(posedge clk_in);
        #2;
        for (int i = 0; i < NL; i++) begin
            lane_done[i] = 1'b0;
            if (!rst_n_in) dcnt[i] = 0;
            else if (lane_start[i]) dcnt[i] = dt_rand ? int'($urandom_range(1, 30)) : dt_fix;
            else if (dcnt[i] > 0) begin
                dcnt[i] = dcnt[i] - 1;
                if (dcnt[i] == 0) lane_done[i] = 1'b1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference lane state: busy from a start pulse until the cycle after
    // its done pulse; round-robin pointer just past the last lane started.
    logic [NL-1:0] act_m, ld_m;
    int            rr_m;
    logic [CW-1:0] held_x [NL], held_y [NL], held_z [NL];
    corner_t       exp_q [$];

    // Observations from the most recent scan.
    int w_starts, w_done, w_done_c, w_ldone_c, w_prev_lane;
    int w_bad_lane, w_bad_corner, w_bad_multi, w_bad_overlap, w_bad_hold, w_bad_busy, w_alt_bad;
    bit w_timeout;
    logic w_aborted;
    logic [WB:0] w_drawn, w_skipped;
    logic [CW-1:0] w_last_x, w_last_y, w_last_z;

    function automatic logic [CW-1:0] corner_of(input logic [15:0] f);
        return CW'(int'($signed(f)) * 65536);
    endfunction

    task automatic reset_model();
        act_m = '0;
        ld_m  = '0;
        rr_m  = 0;
        for (int i = 0; i < NL; i++) begin
            held_x[i] = '0; held_y[i] = '0; held_z[i] = '0;
        end
    endtask

    task automatic build_expected(input int limit);
        corner_t e;
        exp_q.delete();
        for (int a = 0; a < limit && a < WS; a++) begin
            if (mem[a][48]) begin
                e.x = corner_of(mem[a][47:32]);
                e.y = corner_of(mem[a][31:16]);
                e.z = corner_of(mem[a][15:0]);
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic int count_valid(input int limit);
        int n = 0;
        for (int a = 0; a < limit; a++) if (mem[a][48]) n++;
        return n;
    endfunction

    // mode: 0 = entries 0..3 valid, 1 = all valid, 2 = none valid, 3 = random
    task automatic fill_world(input int mode);
        logic v;
        for (int a = 0; a < WS; a++) begin
            case (mode)
                0: v = (a < 4);
                1: v = 1'b1;
                2: v = 1'b0;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            mem[a] = {v, 16'($urandom), 16'($urandom), 16'($urandom)};
        end
    endtask

    // Starts a scan and follows it cycle by cycle, recording what happened.
    task automatic run_scan(input int budget, input int abort_idx, input bit glitch);
        int c, post, at_abort, exp_lane, l;
        corner_t e;
        w_starts = 0; w_done = 0; w_done_c = -1; w_ldone_c = -1; w_prev_lane = -1;
        w_bad_lane = 0; w_bad_corner = 0; w_bad_multi = 0; w_bad_overlap = 0;
        w_bad_hold = 0; w_bad_busy = 0; w_alt_bad = 0;
        w_aborted = 1'b0; w_drawn = '0; w_skipped = '0;
        w_last_x = '0; w_last_y = '0; w_last_z = '0;
        @(negedge clk_in); start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        c = 1; post = 0; at_abort = 0;
        while (c < budget && post < 6) begin
            if ($countones(lane_start) > 1) w_bad_multi++;
            exp_lane = -1;
            for (int k = NL - 1; k >= 0; k--) begin
                l = (rr_m + k) % NL;
                if (!act_m[l]) exp_lane = l;
            end
            for (int i = 0; i < NL; i++) begin
                if (lane_start[i]) begin
                    w_starts++;
                    if (act_m[i]) w_bad_overlap++;
                    if (i != exp_lane) w_bad_lane++;
                    if (w_prev_lane == i) w_alt_bad++;
                    w_prev_lane = i;
                    rr_m = (i + 1) % NL;
                    w_last_x = lane_x_corner[i*CW +: CW];
                    w_last_y = lane_y_corner[i*CW +: CW];
                    w_last_z = lane_z_corner[i*CW +: CW];
                    if (exp_q.size() == 0) w_bad_corner++;
                    else begin
                        e = exp_q.pop_front();
                        if (w_last_x !== e.x || w_last_y !== e.y || w_last_z !== e.z) w_bad_corner++;
                        held_x[i] = e.x; held_y[i] = e.y; held_z[i] = e.z;
                    end
                end else if (lane_x_corner[i*CW +: CW] !== held_x[i] ||
                             lane_y_corner[i*CW +: CW] !== held_y[i] ||
                             lane_z_corner[i*CW +: CW] !== held_z[i]) begin
                    w_bad_hold++;
                end
            end
            act_m = (act_m & ~ld_m) | lane_start;
            ld_m  = lane_done;
            if (lane_done != '0 && w_done == 0) w_ldone_c = c;
            if (done === 1'b1) begin
                w_done++;
                if (w_done == 1) begin
                    w_done_c = c; w_aborted = aborted;
                    w_drawn = cubes_drawn; w_skipped = cubes_skipped;
                end
            end
            if (w_done == 0) begin
                if (busy !== 1'b1) w_bad_busy++;
            end else if (done !== 1'b1 && busy !== 1'b0) w_bad_busy++;
            if (w_done > 0) post++;
            if (abort_idx >= 0 && int'(world_read_addr) == abort_idx) at_abort++;
            abort = (at_abort == 2);
            start = glitch && (c == 20);
            @(negedge clk_in);
            c++;
        end
        abort = 1'b0;
        start = 1'b0;
        w_timeout = (w_done == 0);
        $display("scan: starts=%0d dones=%0d done_cycle=%0d drawn=%0d skipped=%0d aborted=%0b",
                 w_starts, w_done, w_done_c, w_drawn, w_skipped, w_aborted);
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (aborted !== 1'b0) begin n_bad++; $display("FAIL reset_aborted: got %b want 0", aborted); end
        n_cmp++; if (lane_start !== '0) begin n_bad++; $display("FAIL reset_lane_start: got %b want 0", lane_start); end
        n_cmp++; if (world_read_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", world_read_addr); end
        n_cmp++; if (cubes_drawn !== '0 || cubes_skipped !== '0) begin
            n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cubes_drawn, cubes_skipped); end
        n_cmp++; if (lane_x_corner !== '0 || lane_y_corner !== '0 || lane_z_corner !== '0) begin
            n_bad++; $display("FAIL reset_corners: got %h %h %h want 0", lane_x_corner, lane_y_corner, lane_z_corner); end
        rst_n_in = 1'b1;
        reset_model();
        $display("reset: outputs checked");
    endtask

    task automatic test_prefix();
        fill_world(0);
        dt_rand = 1'b0; dt_fix = 10;
        build_expected(WS);
        run_scan(2000, -1, 1'b0);
        n_cmp++; if (w_timeout !== 1'b0) begin n_bad++; $display("FAIL prefix_timeout: got no done want done"); end
        n_cmp++; if (w_starts !== 4) begin n_bad++; $display("FAIL prefix_starts: got %0d want 4", w_starts); end
        n_cmp++; if (w_drawn !== 8'd4) begin n_bad++; $display("FAIL prefix_drawn: got %0d want 4", w_drawn); end
        n_cmp++; if (w_skipped !== 8'(WS - 4)) begin n_bad++; $display("FAIL prefix_skipped: got %0d want %0d", w_skipped, WS - 4); end
        n_cmp++; if (w_done !== 1) begin n_bad++; $display("FAIL prefix_done_pulses: got %0d want 1", w_done); end
        n_cmp++; if (w_aborted !== 1'b0) begin n_bad++; $display("FAIL prefix_aborted: got %b want 0", w_aborted); end
        n_cmp++; if (!(w_done_c > w_ldone_c)) begin
            n_bad++; $display("FAIL prefix_done_order: got done at %0d last lane_done %0d want later", w_done_c, w_ldone_c); end
        n_cmp++; if (w_bad_lane + w_bad_corner + w_bad_multi + w_bad_overlap + w_bad_hold + w_bad_busy !== 0) begin
            n_bad++; $display("FAIL prefix_integrity: got lane=%0d corner=%0d multi=%0d overlap=%0d hold=%0d busy=%0d want all 0",
                              w_bad_lane, w_bad_corner, w_bad_multi, w_bad_overlap, w_bad_hold, w_bad_busy); end
    endtask

    task automatic test_corner_format();
        fill_world(2);
        mem[0] = {1'b1, 16'hFFFD, 16'h0005, 16'h0000};
        dt_rand = 1'b0; dt_fix = 5;
        build_expected(WS);
        run_scan(1000, -1, 1'b0);
        n_cmp++; if (w_starts !== 1) begin n_bad++; $display("FAIL corner_starts: got %0d want 1", w_starts); end
        n_cmp++; if (w_last_x !== 32'hFFFD0000) begin n_bad++; $display("FAIL corner_x: got %h want FFFD0000", w_last_x); end
        n_cmp++; if (w_last_y !== 32'h00050000) begin n_bad++; $display("FAIL corner_y: got %h want 00050000", w_last_y); end
        n_cmp++; if (w_last_z !== 32'h00000000) begin n_bad++; $display("FAIL corner_z: got %h want 00000000", w_last_z); end
        n_cmp++; if (w_bad_hold + w_bad_lane !== 0) begin
            n_bad++; $display("FAIL corner_hold: got hold=%0d lane=%0d want 0", w_bad_hold, w_bad_lane); end
    endtask

    task automatic test_alternate();
        fill_world(1);
        dt_rand = 1'b0; dt_fix = 50;
        build_expected(WS);
        run_scan(8000, -1, 1'b0);
        n_cmp++; if (w_timeout !== 1'b0) begin n_bad++; $display("FAIL alt_timeout: got no done want done"); end
        n_cmp++; if (w_drawn !== 8'(WS)) begin n_bad++; $display("FAIL alt_drawn: got %0d want %0d", w_drawn, WS); end
        n_cmp++; if (w_alt_bad !== 0) begin n_bad++; $display("FAIL alt_sequence: got %0d repeats want 0", w_alt_bad); end
        n_cmp++; if (w_bad_overlap !== 0) begin n_bad++; $display("FAIL alt_overlap: got %0d want 0", w_bad_overlap); end
        n_cmp++; if (w_bad_lane + w_bad_corner + w_bad_hold + w_bad_busy !== 0) begin
            n_bad++; $display("FAIL alt_integrity: got lane=%0d corner=%0d hold=%0d busy=%0d want 0",
                              w_bad_lane, w_bad_corner, w_bad_hold, w_bad_busy); end
    endtask

    task automatic test_abort();
        fill_world(1);
        dt_rand = 1'b0; dt_fix = 100;
        build_expected(5);
        run_scan(2000, 5, 1'b0);
        n_cmp++; if (w_timeout !== 1'b0) begin n_bad++; $display("FAIL abort_timeout: got no done want done"); end
        n_cmp++; if (w_aborted !== 1'b1) begin n_bad++; $display("FAIL abort_flag: got %b want 1", w_aborted); end
        n_cmp++; if (w_drawn !== 8'd5) begin n_bad++; $display("FAIL abort_drawn: got %0d want 5", w_drawn); end
        n_cmp++; if (w_starts !== 5) begin n_bad++; $display("FAIL abort_starts: got %0d want 5", w_starts); end
        n_cmp++; if (!(w_done_c > w_ldone_c)) begin
            n_bad++; $display("FAIL abort_drain: got done at %0d last lane_done %0d want later", w_done_c, w_ldone_c); end
        n_cmp++; if (w_bad_corner + w_bad_lane + w_bad_overlap !== 0) begin
            n_bad++; $display("FAIL abort_integrity: got corner=%0d lane=%0d overlap=%0d want 0",
                              w_bad_corner, w_bad_lane, w_bad_overlap); end
    endtask

    task automatic test_reset_mid();
        int nv;
        fill_world(3);
        dt_rand = 1'b1;
        @(negedge clk_in); start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        repeat ($urandom_range(30, 150)) @(negedge clk_in);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (lane_start !== '0) begin n_bad++; $display("FAIL midrst_lane_start: got %b want 0", lane_start); end
        n_cmp++; if (cubes_drawn !== '0 || cubes_skipped !== '0) begin
            n_bad++; $display("FAIL midrst_counters: got %0d/%0d want 0/0", cubes_drawn, cubes_skipped); end
        n_cmp++; if (world_read_addr !== '0) begin n_bad++; $display("FAIL midrst_addr: got %0d want 0", world_read_addr); end
        rst_n_in = 1'b1;
        reset_model();
        $display("reset mid-scan: outputs checked");
        nv = count_valid(WS);
        build_expected(WS);
        run_scan(6000, -1, 1'b0);
        n_cmp++; if (w_drawn !== 8'(nv) || w_skipped !== 8'(WS - nv)) begin
            n_bad++; $display("FAIL midrst_rescan: got %0d/%0d want %0d/%0d", w_drawn, w_skipped, nv, WS - nv); end
        n_cmp++; if (w_bad_corner + w_bad_lane + w_bad_hold + w_bad_overlap !== 0 || w_timeout) begin
            n_bad++; $display("FAIL midrst_integrity: got corner=%0d lane=%0d hold=%0d overlap=%0d timeout=%0b want 0",
                              w_bad_corner, w_bad_lane, w_bad_hold, w_bad_overlap, w_timeout); end
    endtask

    task automatic test_all_invalid();
        int lo, hi;
        fill_world(2);
        dt_rand = 1'b0; dt_fix = 10;
        build_expected(WS);
        run_scan(1000, -1, 1'b0);
        lo = WS * (LAT + 2);
        hi = lo + 4;
        n_cmp++; if (w_starts !== 0) begin n_bad++; $display("FAIL inval_starts: got %0d want 0", w_starts); end
        n_cmp++; if (w_skipped !== 8'(WS) || w_drawn !== 8'd0) begin
            n_bad++; $display("FAIL inval_counters: got %0d/%0d want 0/%0d", w_drawn, w_skipped, WS); end
        n_cmp++; if (w_done_c < lo || w_done_c > hi) begin
            n_bad++; $display("FAIL inval_timing: got done at cycle %0d want %0d..%0d", w_done_c, lo, hi); end
    endtask

    task automatic test_random();
        int nv;
        fill_world(3);
        dt_rand = 1'b1;
        nv = count_valid(WS);
        build_expected(WS);
        run_scan(6000, -1, 1'b1);
        n_cmp++; if (w_drawn !== 8'(nv) || w_skipped !== 8'(WS - nv)) begin
            n_bad++; $display("FAIL rand_counters: got %0d/%0d want %0d/%0d", w_drawn, w_skipped, nv, WS - nv); end
        n_cmp++; if (w_starts !== nv || w_done !== 1 || w_timeout) begin
            n_bad++; $display("FAIL rand_flow: got starts=%0d dones=%0d timeout=%0b want %0d/1/0",
                              w_starts, w_done, w_timeout, nv); end
        n_cmp++; if (w_bad_lane + w_bad_corner + w_bad_multi + w_bad_overlap + w_bad_hold + w_bad_busy !== 0) begin
            n_bad++; $display("FAIL rand_integrity: got lane=%0d corner=%0d multi=%0d overlap=%0d hold=%0d busy=%0d want 0",
                              w_bad_lane, w_bad_corner, w_bad_multi, w_bad_overlap, w_bad_hold, w_bad_busy); end
    endtask

    initial begin
        for (int a = 0; a < WS; a++) mem[a] = '0;
        reset_model();
        test_reset();
        test_prefix();
        test_corner_format();
        test_alternate();
        test_abort();
        test_reset_mid();
        test_all_invalid();
        test_random();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
